// File: rtl/rev_bcd_tick_counter.sv
// rtl/rev_bcd_tick_counter.sv - slow_clk edge-to-tick synchronizer driving a BCD up/down counter
// Optional: define REV_COUNTER_PINGPONG_EN for a bounce-at-terminal direction register.
module rev_bcd_tick_counter #(
    parameter int DIGITS      = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  slow_clk,
    input  logic                  en,
    input  logic                  dir,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   count,
    output logic                  tick,
    output logic                  wrap,
    output logic                  cur_dir
);
    localparam int W = 4 * DIGITS;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    logic                   tick_q, tick_d;
    logic                   wrap_q, wrap_d;
    logic [W-1:0]           count_q, count_d;
    logic                   dir_q, dir_d;
    logic                   rise;
    logic                   step_up;

    function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (v[4*i +: 4] >= 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         borrow;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (borrow) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [W-1:0] bcd_clamp(input logic [W-1:0] v);
        logic [W-1:0] r;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = (v[4*i +: 4] > 4'd9) ? 4'd9 : v[4*i +: 4];
        end
        return r;
    endfunction

    function automatic logic all_nines(input logic [W-1:0] v);
        logic r;
        r = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] != 4'd9) r = 1'b0;
        end
        return r;
    endfunction

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], slow_clk};
        prev_d  = sync_q[SYNC_STAGES-1];
        rise    = sync_q[SYNC_STAGES-1] & ~prev_q;
        tick_d  = rise;
        wrap_d  = 1'b0;
        count_d = count_q;
`ifdef REV_COUNTER_PINGPONG_EN
        dir_d   = dir_q;
        step_up = dir_q;
`else
        dir_d   = dir;
        step_up = dir;
`endif
        if (load) begin
            count_d = bcd_clamp(load_val);
`ifdef REV_COUNTER_PINGPONG_EN
            dir_d   = dir;
`endif
        end else if (rise && en) begin
            if (step_up) begin
                if (all_nines(count_q)) begin
                    wrap_d = 1'b1;
`ifdef REV_COUNTER_PINGPONG_EN
                    // Bounce: reverse direction and move one step away from the terminal.
                    count_d = bcd_dec(count_q);
                    dir_d   = 1'b0;
`else
                    count_d = '0;
`endif
                end else begin
                    count_d = bcd_inc(count_q);
                end
            end else begin
                if (count_q == '0) begin
                    wrap_d = 1'b1;
`ifdef REV_COUNTER_PINGPONG_EN
                    count_d = bcd_inc(count_q);
                    dir_d   = 1'b1;
`else
                    count_d = bcd_dec(count_q);
`endif
                end else begin
                    count_d = bcd_dec(count_q);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            prev_q  <= 1'b0;
            tick_q  <= 1'b0;
            wrap_q  <= 1'b0;
            count_q <= '0;
            dir_q   <= 1'b1;
        end else begin
            sync_q  <= sync_d;
            prev_q  <= prev_d;
            tick_q  <= tick_d;
            wrap_q  <= wrap_d;
            count_q <= count_d;
            dir_q   <= dir_d;
        end
    end

    assign count   = count_q;
    assign tick    = tick_q;
    assign wrap    = wrap_q;
    assign cur_dir = dir_q;

endmodule
